rf_wb_queue: RTL
================

Name: rf_wb_queue

Overview:
- Writer-side front end for the 2R1W register file's single write port (`we`/`wa`/`wd`).
- Accepts writeback requests from two producers, the memory/load path and the ALU path, each over a valid/ready handshake.
- Serialises accepted requests into at most one register-file write per cycle, buffering overflow in an in-order queue.
- Exposes a query port so decode can detect a pending write to a source register and forward its value.

Parameters:
- DEPTH, 4, queue entries (>=2), excluding the output register.
- DWIDTH, 32, data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- m_valid  in  1  memory/load writeback request valid.
- m_ready  out  1  memory request accepted this cycle when m_valid & m_ready.
- m_rd  in  5  memory destination register.
- m_data  in  DWIDTH  memory writeback data.
- a_valid  in  1  ALU writeback request valid.
- a_ready  out  1  ALU request accepted this cycle when a_valid & a_ready.
- a_rd  in  5  ALU destination register.
- a_data  in  DWIDTH  ALU writeback data.
- rf_we  out  1  register file write enable, registered.
- rf_wa  out  5  register file write address, registered.
- rf_wd  out  DWIDTH  register file write data, registered.
- q_rd  in  5  query register index.
- q_pending  out  1  a write to q_rd is queued or on rf_w*.
- q_data  out  DWIDTH  data of the youngest pending write to q_rd, else 0.

Behaviour:
- Clock and reset: single clock domain; reset asynchronous, active-high.
- Reset values: count=0, all entries invalid, rf_we=0, rf_wa=0, rf_wd=0.
  - Consequently q_pending=0 and q_data=0 during reset.
  - Reset mid-operation discards all queued and in-flight writes; nothing reaches rf_we afterwards.
- Ready rules: combinational from registered count only, independent of valid.
  - m_ready = (count < DEPTH).
  - a_ready = (count < DEPTH-1).
- Fire: m_fire = m_valid & m_ready; a_fire = a_valid & a_ready.
- x0 filter: a fired request with rd==0 is consumed (handshake completes) and dropped. It is never enqueued, never written and never reported pending.
- Per rising edge, form ordered list L:
  - queue entries, oldest first;
  - then the memory request if m_fire and m_rd!=0;
  - then the ALU request if a_fire and a_rd!=0.
- Edge update:
  - If L is non-empty: {rf_wa, rf_wd} <= L[0], rf_we <= 1, queue <= L[1..], count <= len(L)-1.
  - If L is empty: rf_we <= 0, count <= 0; rf_wa and rf_wd hold their previous values.
- Latency: a request accepted in cycle N with an empty queue appears on rf_w* in cycle N+1. The register file commits it at the edge ending cycle N+1.
- Ordering:
  - Strict acceptance order.
  - Same-cycle fires: memory precedes ALU.
  - No reordering, no coalescing of writes to the same rd; both are issued.
- Occupancy: count never exceeds DEPTH-1 under these ready rules.
  - m_ready stays high because drain is 1/cycle.
  - a_ready deasserts exactly when count == DEPTH-1.
- Query: combinational over registered state (queue entries plus the output register when rf_we=1).
  - q_pending = 1 iff q_rd != 0 and some valid entry matches q_rd.
  - q_data = data of the youngest matching entry; queue tail is youngest, output register is oldest.
  - q_data = 0 when q_pending = 0.
  - Requests presented in the current cycle are not visible to the query.
- No internal read of the register file; rf_we is held low whenever there is no work.

Test Plan:
- Empty queue; ALU x7=123 for one cycle -> a_ready=1. Next cycle rf_we=1, rf_wa=7, rf_wd=123. Following cycle rf_we=0; reg file read of x7 returns 123.
- Same cycle memory x5=0xAA and ALU x6=0xBB -> both fire. Cycle+1 writes x5=0xAA, cycle+2 writes x6=0xBB, cycle+3 rf_we=0.
- ALU x0=0xFFFF -> a_ready=1, rf_we never asserts, q_pending for q_rd=0 stays 0. A reg file read of x0 still returns 0.
- DEPTH=4, both channels valid every cycle with distinct rd -> a_ready drops once count reaches 3, while m_ready stays 1. Writes emerge in acceptance order, one per cycle, with no loss or duplication.
- Queue holds x9=1 then x9=2 (older first), q_rd=9 -> q_pending=1, q_data=2. After both drain, q_pending=0 and q_data=0.
- Three entries queued, then rst asserted asynchronously mid-cycle -> rf_we=0 immediately, count=0, q_pending=0. After rst drops, no stale writes appear.

Source files
------------

// File: rtl/rf_wb_queue_if.sv
// Handshake, register-file write and query signals of the writeback queue.
// The master side drives requests and the query index; the slave side is the queue.
interface rf_wb_queue_if #(
  parameter int DWIDTH = 32
);
  logic              m_valid;
  logic              m_ready;
  logic [4:0]        m_rd;
  logic [DWIDTH-1:0] m_data;
  logic              a_valid;
  logic              a_ready;
  logic [4:0]        a_rd;
  logic [DWIDTH-1:0] a_data;
  logic              rf_we;
  logic [4:0]        rf_wa;
  logic [DWIDTH-1:0] rf_wd;
  logic [4:0]        q_rd;
  logic              q_pending;
  logic [DWIDTH-1:0] q_data;

  modport master (
    output m_valid, m_rd, m_data, a_valid, a_rd, a_data, q_rd,
    input  m_ready, a_ready, rf_we, rf_wa, rf_wd, q_pending, q_data
  );

  modport slave (
    input  m_valid, m_rd, m_data, a_valid, a_rd, a_data, q_rd,
    output m_ready, a_ready, rf_we, rf_wa, rf_wd, q_pending, q_data
  );
endinterface

// File: rtl/rf_wb_queue.sv
// Merges memory and ALU writebacks into one in-order register-file write per cycle,
// with a pending-write query port for decode forwarding.
module rf_wb_queue #(
  parameter int DEPTH  = 4,
  parameter int DWIDTH = 32
) (
  input logic          clk,
  input logic          rst,
  rf_wb_queue_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0]     count_reg;
  logic [CW-1:0]     count_next;
  logic [4:0]        ent_rd_reg   [DEPTH];
  logic [DWIDTH-1:0] ent_data_reg [DEPTH];
  logic [4:0]        ent_rd_next  [DEPTH];
  logic [DWIDTH-1:0] ent_data_next[DEPTH];

  logic              we_reg;
  logic [4:0]        wa_reg;
  logic [DWIDTH-1:0] wd_reg;

  logic              m_fire, a_fire, m_ins, a_ins;
  logic              l_empty;
  logic [4:0]        head_rd;
  logic [DWIDTH-1:0] head_data;
  logic [CW:0]       l_len;

  assign bus.m_ready = (count_reg < CW'(DEPTH));
  assign bus.a_ready = (count_reg < CW'(DEPTH - 1));

  assign m_fire = bus.m_valid & bus.m_ready;
  assign a_fire = bus.a_valid & bus.a_ready;
  // x0 writes complete their handshake but never enter the list
  assign m_ins  = m_fire & (bus.m_rd != 5'd0);
  assign a_ins  = a_fire & (bus.a_rd != 5'd0);

  assign l_len   = {1'b0, count_reg} + (CW+1)'(m_ins) + (CW+1)'(a_ins);
  assign l_empty = (l_len == '0);

  always_comb begin
    head_rd   = bus.a_rd;
    head_data = bus.a_data;
    if (count_reg != '0) begin
      head_rd   = ent_rd_reg[0];
      head_data = ent_data_reg[0];
    end else if (m_ins) begin
      head_rd   = bus.m_rd;
      head_data = bus.m_data;
    end
  end

  always_comb begin
    count_next = '0;
    if (!l_empty) begin
      count_next = CW'(l_len - 1'b1);
    end
  end

  // Slot gi takes list element gi+1: an older entry, else the memory request, else the ALU request
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
      localparam logic [CW-1:0] K = CW'(gi + 1);
      if (gi < DEPTH - 1) begin : g_mid
        always_comb begin
          ent_rd_next[gi]   = bus.a_rd;
          ent_data_next[gi] = bus.a_data;
          if (K < count_reg) begin
            ent_rd_next[gi]   = ent_rd_reg[gi+1];
            ent_data_next[gi] = ent_data_reg[gi+1];
          end else if ((K == count_reg) && m_ins) begin
            ent_rd_next[gi]   = bus.m_rd;
            ent_data_next[gi] = bus.m_data;
          end
        end
      end else begin : g_last
        always_comb begin
          ent_rd_next[gi]   = bus.a_rd;
          ent_data_next[gi] = bus.a_data;
          if ((K == count_reg) && m_ins) begin
            ent_rd_next[gi]   = bus.m_rd;
            ent_data_next[gi] = bus.m_data;
          end
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ent_rd_reg[gi]   <= '0;
          ent_data_reg[gi] <= '0;
        end else begin
          ent_rd_reg[gi]   <= ent_rd_next[gi];
          ent_data_reg[gi] <= ent_data_next[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
      we_reg    <= 1'b0;
      wa_reg    <= '0;
      wd_reg    <= '0;
    end else begin
      count_reg <= count_next;
      we_reg    <= !l_empty;
      if (!l_empty) begin
        wa_reg <= head_rd;
        wd_reg <= head_data;
      end
    end
  end

  assign bus.rf_we = we_reg;
  assign bus.rf_wa = wa_reg;
  assign bus.rf_wd = wd_reg;

  // Scan oldest to youngest so the last match is the youngest pending write
  always_comb begin
    bus.q_pending = 1'b0;
    bus.q_data    = '0;
    if (we_reg && (wa_reg == bus.q_rd)) begin
      bus.q_pending = 1'b1;
      bus.q_data    = wd_reg;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count_reg) && (ent_rd_reg[i] == bus.q_rd)) begin
        bus.q_pending = 1'b1;
        bus.q_data    = ent_data_reg[i];
      end
    end
    if (bus.q_rd == 5'd0) begin
      bus.q_pending = 1'b0;
      bus.q_data    = '0;
    end
  end
endmodule
